// File: rtl/sdram_matrix_loader.sv
// sdram_matrix_loader: Avalon-MM read master copying an n x n matrix from SDRAM into on-chip RAM
module sdram_matrix_loader #(
    parameter logic [7:0] DEFAULT_DIMENSION = 8'd16,
    parameter int         MAX_PENDING       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] base_addr,
    input  logic [7:0]  dimension,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [23:0] address,
    output logic        read,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    input  logic        waitrequest,
    output logic [9:0]  ram_wraddress,
    output logic [31:0] ram_data,
    output logic        ram_wren
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FINISH = 2'd3;
    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);
    logic [1:0]  state;
    logic [10:0] total, issued, received, issued_next;
    logic [3:0]  pending, pending_next;
    logic [7:0]  n_eff;
    logic        active, accept, rsp, retire, last_write;
    always_comb begin
        n_eff = dimension == 8'd0 ? DEFAULT_DIMENSION : dimension;
        active = state == ISSUE || state == DRAIN;
        accept = read && !waitrequest;
        rsp = readdatavalid && active;
        retire = rsp && (pending != 4'd0 || accept);
        issued_next = issued + {10'd0, accept};
        pending_next = pending + {3'd0, accept} - {3'd0, retire};
        last_write = active && ram_wren && received == total;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            read <= 1'b0;
            address <= '0;
            ram_wren <= 1'b0;
            ram_wraddress <= '0;
            ram_data <= '0;
            total <= '0;
            issued <= '0;
            received <= '0;
            pending <= '0;
        end else begin
            done <= 1'b0;
            error <= 1'b0;
            ram_wren <= rsp;
            if (rsp) begin
                ram_wraddress <= received[9:0];
                ram_data <= readdata;
                received <= received + 11'd1;
            end
            if (active) pending <= pending_next;
            if (state == ISSUE) begin
                issued <= issued_next;
                read <= issued_next < total && pending_next < MAX_P;
                if (accept) address <= address + 24'd4;
                if (issued_next == total) state <= DRAIN;
            end
            if (state == IDLE && start) begin
                if (n_eff > 8'd32 || base_addr[1:0] != 2'b00) begin
                    state <= FINISH;
                    done <= 1'b1;
                    error <= 1'b1;
                end else begin
                    state <= ISSUE;
                    busy <= 1'b1;
                    read <= 1'b1;
                    address <= base_addr;
                    total <= {3'd0, n_eff} * {3'd0, n_eff};
                    issued <= '0;
                    received <= '0;
                    pending <= '0;
                end
            end
            // the final word's write is on the bus this cycle, so completion follows it
            if (last_write) begin
                state <= FINISH;
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (state == FINISH) state <= IDLE;
        end
    end
endmodule
